// File: rtl/fsmc_pkg.sv
// Shared definitions for the FSMC channel bridge.
//   fsmc_state_t : bus-transaction FSM states
//   WIN_*        : default window codes of each FPGA address window
package fsmc_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_ADDR,
        ST_ARMED,
        ST_WRITE,
        ST_READ,
        ST_MISS
    } fsmc_state_t;

    localparam logic [3:0] WIN_DDS    = 4'b1010;
    localparam logic [3:0] WIN_BUF    = 4'b1110;
    localparam logic [3:0] WIN_STATUS = 4'b1111;

endpackage

// File: rtl/fsmc_sync.sv
// Multi-flop synchroniser for one active-low FSMC strobe plus edge detector.
//   CLK, RST_N : clock, asynchronous active-low reset
//   raw        : asynchronous strobe from the pad
//   level      : synchronised strobe
//   rise, fall : single-cycle edge flags of the synchronised strobe
// The chain resets to the idle (high) level so that leaving reset while the
// bus is quiet never produces a spurious edge.
module fsmc_sync #(
    parameter int   STAGES  = 2,
    parameter logic RST_VAL = 1'b1
) (
    input  logic CLK,
    input  logic RST_N,
    input  logic raw,
    output logic level,
    output logic rise,
    output logic fall
);

    logic [STAGES-1:0] sync_reg;
    logic              prev_reg;

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            sync_reg <= {STAGES{RST_VAL}};
            prev_reg <= RST_VAL;
        end else begin
            sync_reg <= {sync_reg[STAGES-2:0], raw};
            prev_reg <= sync_reg[STAGES-1];
        end
    end

    assign level = sync_reg[STAGES-1];
    assign rise  = level & ~prev_reg;
    assign fall  = ~level & prev_reg;

endmodule

// File: rtl/fsmc_chan_bridge.sv
// Synchronous slave for the STM32 FSMC multiplexed address/data bus.
//   CLK, RST_N          : clock, asynchronous active-low reset
//   NE/NADV/NOE/NWE     : raw active-low bus strobes
//   A_HI, AD_IN         : upper address pins and AD pad input
//   AD_OUT, AD_OE       : AD pad output data and output enable
//   WR_*                : one-cycle write strobe with channel/register/data,
//                         WR_TOGGLE flips per channel on each write
//   RD_REQ/RD_CH/RD_REG : one-cycle read request to the fabric
//   RD_ACK, RD_DATA     : fabric read response
//   RD_LATE             : sticky, a read ended before the fabric answered
module fsmc_chan_bridge
    import fsmc_pkg::*;
#(
    parameter int                  ADDR_W      = 19,
    parameter int                  DATA_W      = 16,
    parameter int                  WIN_BITS    = 4,
    parameter logic [WIN_BITS-1:0] WIN_ID      = WIN_DDS,
    parameter int                  CH_BITS     = 2,
    parameter int                  REG_BITS    = 8,
    parameter int                  SYNC_STAGES = 2
) (
    input  logic                       CLK,
    input  logic                       RST_N,
    input  logic                       NE,
    input  logic                       NADV,
    input  logic                       NOE,
    input  logic                       NWE,
    input  logic [ADDR_W-DATA_W-1:0]   A_HI,
    input  logic [DATA_W-1:0]          AD_IN,
    output logic [DATA_W-1:0]          AD_OUT,
    output logic                       AD_OE,
    output logic                       WR_VALID,
    output logic [CH_BITS-1:0]         WR_CH,
    output logic [REG_BITS-1:0]        WR_REG,
    output logic [DATA_W-1:0]          WR_DATA,
    output logic [(1<<CH_BITS)-1:0]    WR_TOGGLE,
    output logic                       RD_REQ,
    output logic [CH_BITS-1:0]         RD_CH,
    output logic [REG_BITS-1:0]        RD_REG,
    input  logic                       RD_ACK,
    input  logic [DATA_W-1:0]          RD_DATA,
    output logic                       RD_LATE
);

    localparam int NUM_CH = 1 << CH_BITS;

    // Strobe index: 0 NE, 1 NADV, 2 NOE, 3 NWE
    logic [3:0] strobe_raw;
    logic [3:0] strobe_lvl;
    logic [3:0] strobe_rise;
    logic [3:0] strobe_fall;

    assign strobe_raw = {NWE, NOE, NADV, NE};

    genvar gi;
    generate
        for (gi = 0; gi < 4; gi++) begin : g_sync
            fsmc_sync #(
                .STAGES  (SYNC_STAGES),
                .RST_VAL (1'b1)
            ) u_sync (
                .CLK   (CLK),
                .RST_N (RST_N),
                .raw   (strobe_raw[gi]),
                .level (strobe_lvl[gi]),
                .rise  (strobe_rise[gi]),
                .fall  (strobe_fall[gi])
            );
        end
    endgenerate

    logic ne_lvl, ne_rise, ne_fall, nadv_rise, noe_rise, noe_fall, nwe_rise, nwe_fall;
    assign ne_lvl    = strobe_lvl[0];
    assign ne_rise   = strobe_rise[0];
    assign ne_fall   = strobe_fall[0];
    assign nadv_rise = strobe_rise[1];
    assign noe_rise  = strobe_rise[2];
    assign noe_fall  = strobe_fall[2];
    assign nwe_rise  = strobe_rise[3];
    assign nwe_fall  = strobe_fall[3];

    // Address/data delay line of the same depth as the strobe synchronisers,
    // so the oldest entry is exactly the bus value seen with the edge flags.
    logic [SYNC_STAGES-1:0][ADDR_W-1:0] bus_dly_reg;
    logic [ADDR_W-1:0]                  bus_aligned;

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            bus_dly_reg <= '0;
        end else begin
            bus_dly_reg <= {bus_dly_reg[SYNC_STAGES-2:0], {A_HI, AD_IN}};
        end
    end

    assign bus_aligned = bus_dly_reg[SYNC_STAGES-1];

    // Address latch and decode. The window hit is taken from the value being
    // latched so the FSM can branch in the same cycle as the capture.
    logic [ADDR_W-1:0]   addr_reg;
    logic                cap_hit;
    logic [CH_BITS-1:0]  addr_ch;
    logic [REG_BITS-1:0] addr_idx;

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            addr_reg <= '0;
        end else if (nadv_rise && !ne_lvl) begin
            addr_reg <= bus_aligned;
        end
    end

    assign cap_hit  = (bus_aligned[ADDR_W-1 -: WIN_BITS] == WIN_ID);
    assign addr_ch  = addr_reg[REG_BITS +: CH_BITS];
    assign addr_idx = addr_reg[REG_BITS-1:0];

    logic unused_bits;
    assign unused_bits = ^{strobe_lvl[3:1], strobe_fall[1], addr_reg[ADDR_W-1:REG_BITS+CH_BITS]};

    // FSM and output registers
    fsmc_state_t         state_reg,     state_next;
    logic [DATA_W-1:0]   ad_out_reg,    ad_out_next;
    logic                ad_oe_reg,     ad_oe_next;
    logic                wr_valid_reg,  wr_valid_next;
    logic [CH_BITS-1:0]  wr_ch_reg,     wr_ch_next;
    logic [REG_BITS-1:0] wr_idx_reg,    wr_idx_next;
    logic [DATA_W-1:0]   wr_data_reg,   wr_data_next;
    logic [NUM_CH-1:0]   wr_toggle_reg, wr_toggle_next;
    logic                rd_req_reg,    rd_req_next;
    logic [CH_BITS-1:0]  rd_ch_reg,     rd_ch_next;
    logic [REG_BITS-1:0] rd_idx_reg,    rd_idx_next;
    logic                rd_late_reg,   rd_late_next;
    logic                ack_seen_reg,  ack_seen_next;

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state_reg     <= ST_IDLE;
            ad_out_reg    <= '0;
            ad_oe_reg     <= 1'b0;
            wr_valid_reg  <= 1'b0;
            wr_ch_reg     <= '0;
            wr_idx_reg    <= '0;
            wr_data_reg   <= '0;
            wr_toggle_reg <= '0;
            rd_req_reg    <= 1'b0;
            rd_ch_reg     <= '0;
            rd_idx_reg    <= '0;
            rd_late_reg   <= 1'b0;
            ack_seen_reg  <= 1'b0;
        end else begin
            state_reg     <= state_next;
            ad_out_reg    <= ad_out_next;
            ad_oe_reg     <= ad_oe_next;
            wr_valid_reg  <= wr_valid_next;
            wr_ch_reg     <= wr_ch_next;
            wr_idx_reg    <= wr_idx_next;
            wr_data_reg   <= wr_data_next;
            wr_toggle_reg <= wr_toggle_next;
            rd_req_reg    <= rd_req_next;
            rd_ch_reg     <= rd_ch_next;
            rd_idx_reg    <= rd_idx_next;
            rd_late_reg   <= rd_late_next;
            ack_seen_reg  <= ack_seen_next;
        end
    end

    always_comb begin
        state_next     = state_reg;
        ad_out_next    = ad_out_reg;
        ad_oe_next     = ad_oe_reg;
        wr_valid_next  = 1'b0;
        wr_ch_next     = wr_ch_reg;
        wr_idx_next    = wr_idx_reg;
        wr_data_next   = wr_data_reg;
        wr_toggle_next = wr_toggle_reg;
        rd_req_next    = 1'b0;
        rd_ch_next     = rd_ch_reg;
        rd_idx_next    = rd_idx_reg;
        rd_late_next   = rd_late_reg;
        ack_seen_next  = ack_seen_reg;

        if (ne_rise) begin
            // Chip-select release aborts whatever is in flight.
            state_next  = ST_IDLE;
            ad_oe_next  = 1'b0;
            ad_out_next = '0;
        end else begin
            case (state_reg)
                ST_IDLE: begin
                    if (ne_fall) state_next = ST_ADDR;
                end
                ST_ADDR: begin
                    if (nadv_rise) state_next = cap_hit ? ST_ARMED : ST_MISS;
                end
                ST_ARMED: begin
                    // Write wins if both strobes fall together.
                    if (nwe_fall) begin
                        state_next = ST_WRITE;
                    end else if (noe_fall) begin
                        state_next    = ST_READ;
                        rd_req_next   = 1'b1;
                        rd_ch_next    = addr_ch;
                        rd_idx_next   = addr_idx;
                        ad_oe_next    = 1'b1;
                        ad_out_next   = '0;
                        ack_seen_next = 1'b0;
                    end
                end
                ST_WRITE: begin
                    if (nwe_rise) begin
                        state_next              = ST_IDLE;
                        wr_valid_next           = 1'b1;
                        wr_ch_next              = addr_ch;
                        wr_idx_next             = addr_idx;
                        wr_data_next            = bus_aligned[DATA_W-1:0];
                        wr_toggle_next[addr_ch] = ~wr_toggle_reg[addr_ch];
                    end
                end
                ST_READ: begin
                    if (noe_rise) begin
                        state_next  = ST_IDLE;
                        ad_oe_next  = 1'b0;
                        ad_out_next = '0;
                        if (!ack_seen_reg) rd_late_next = 1'b1;
                    end else if (RD_ACK && !ack_seen_reg) begin
                        ad_out_next   = RD_DATA;
                        ack_seen_next = 1'b1;
                    end
                end
                ST_MISS: begin
                    // Foreign window: wait for chip-select release.
                end
                default: state_next = ST_IDLE;
            endcase
        end
    end

    assign AD_OUT    = ad_out_reg;
    assign AD_OE     = ad_oe_reg;
    assign WR_VALID  = wr_valid_reg;
    assign WR_CH     = wr_ch_reg;
    assign WR_REG    = wr_idx_reg;
    assign WR_DATA   = wr_data_reg;
    assign WR_TOGGLE = wr_toggle_reg;
    assign RD_REQ    = rd_req_reg;
    assign RD_CH     = rd_ch_reg;
    assign RD_REG    = rd_idx_reg;
    assign RD_LATE   = rd_late_reg;

endmodule

// File: tb/tb_fsmc_chan_bridge.sv
module tb_fsmc_chan_bridge;

    logic        CLK = 1'b0;
    logic        RST_N = 1'b0;
    logic        NE = 1'b1, NADV = 1'b1, NOE = 1'b1, NWE = 1'b1;
    logic [2:0]  A_HI = '0;
    logic [15:0] AD_IN = '0;
    logic [15:0] AD_OUT;
    logic        AD_OE;
    logic        WR_VALID;
    logic [1:0]  WR_CH;
    logic [7:0]  WR_REG;
    logic [15:0] WR_DATA;
    logic [3:0]  WR_TOGGLE;
    logic        RD_REQ;
    logic [1:0]  RD_CH;
    logic [7:0]  RD_REG;
    logic        RD_ACK = 1'b0;
    logic [15:0] RD_DATA = '0;
    logic        RD_LATE;

    always #5 CLK = ~CLK;

    fsmc_chan_bridge dut (
        .CLK       (CLK),
        .RST_N     (RST_N),
        .NE        (NE),
        .NADV      (NADV),
        .NOE       (NOE),
        .NWE       (NWE),
        .A_HI      (A_HI),
        .AD_IN     (AD_IN),
        .AD_OUT    (AD_OUT),
        .AD_OE     (AD_OE),
        .WR_VALID  (WR_VALID),
        .WR_CH     (WR_CH),
        .WR_REG    (WR_REG),
        .WR_DATA   (WR_DATA),
        .WR_TOGGLE (WR_TOGGLE),
        .RD_REQ    (RD_REQ),
        .RD_CH     (RD_CH),
        .RD_REG    (RD_REG),
        .RD_ACK    (RD_ACK),
        .RD_DATA   (RD_DATA),
        .RD_LATE   (RD_LATE)
    );

    int total = 0;
    int bad   = 0;

    // Pulse / activity counters sampled on the falling edge
    int wr_cnt = 0, rd_cnt = 0, oe_cnt = 0;
    always @(negedge CLK) begin
        if (WR_VALID) wr_cnt <= wr_cnt + 1;
        if (RD_REQ)   rd_cnt <= rd_cnt + 1;
        if (AD_OE)    oe_cnt <= oe_cnt + 1;
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h, want %0h", nm, act, exp);
        end
    endtask

    task automatic addr_phase(input logic [18:0] a);
        @(negedge CLK);
        NE = 1'b0; NADV = 1'b0; A_HI = a[18:16]; AD_IN = a[15:0];
        repeat (5) @(negedge CLK);
        NADV = 1'b1;
        repeat (2) @(negedge CLK);
    endtask

    task automatic bus_write(input logic [18:0] a, input logic [15:0] d);
        addr_phase(a);
        AD_IN = d; NWE = 1'b0;
        repeat (6) @(negedge CLK);
        NWE = 1'b1;
        repeat (2) @(negedge CLK);
        NE = 1'b1; AD_IN = '0; A_HI = '0;
        repeat (6) @(negedge CLK);
    endtask

    // dly < 0: fabric never acknowledges
    task automatic bus_read(input logic [18:0] a, input int dly, input logic [15:0] d,
                            output logic [15:0] out_s, output logic oe_s);
        addr_phase(a);
        AD_IN = '0; NOE = 1'b0;
        repeat (3) @(negedge CLK);
        if (dly >= 0) begin
            repeat (dly) @(negedge CLK);
            RD_ACK = 1'b1; RD_DATA = d;
            @(negedge CLK);
            RD_ACK = 1'b0; RD_DATA = '0;
        end
        repeat (3) @(negedge CLK);
        out_s = AD_OUT;
        oe_s  = AD_OE;
        NOE = 1'b1;
        repeat (2) @(negedge CLK);
        NE = 1'b1; A_HI = '0;
        repeat (6) @(negedge CLK);
    endtask

    typedef struct {
        bit          is_wr;
        logic [18:0] addr;
        logic [15:0] data;
        int          dly;
        int          e_wr;
        int          e_rd;
        bit          e_oe;
        logic [15:0] e_adout;
        logic [3:0]  e_tog;
        bit          e_late;
        logic [1:0]  e_wch;
        logic [7:0]  e_wreg;
        logic [15:0] e_wdata;
        logic [1:0]  e_rch;
        logic [7:0]  e_rreg;
    } vec_t;

    vec_t vecs[8];

    initial begin
        logic [15:0] out_s;
        logic        oe_s;
        int w0, r0, o0;

        //          wr    addr        data      dly wr rd oe  adout     tog    late  wch    wreg   wdata     rch    rreg
        vecs[0] = '{1'b1, 19'h50205, 16'h1234,  0, 1, 0, 0, 16'h0000, 4'h4, 1'b0, 2'd2, 8'h05, 16'h1234, 2'd0, 8'h00};
        vecs[1] = '{1'b0, 19'h50110, 16'hBEEF,  2, 0, 1, 1, 16'hBEEF, 4'h4, 1'b0, 2'd2, 8'h05, 16'h1234, 2'd1, 8'h10};
        vecs[2] = '{1'b1, 19'h70000, 16'h9999,  0, 0, 0, 0, 16'h0000, 4'h4, 1'b0, 2'd2, 8'h05, 16'h1234, 2'd1, 8'h10};
        vecs[3] = '{1'b0, 19'h70000, 16'h1111,  2, 0, 0, 0, 16'h0000, 4'h4, 1'b0, 2'd2, 8'h05, 16'h1234, 2'd1, 8'h10};
        vecs[4] = '{1'b1, 19'h50300, 16'hA5A5,  0, 1, 0, 0, 16'h0000, 4'hC, 1'b0, 2'd3, 8'h00, 16'hA5A5, 2'd1, 8'h10};
        vecs[5] = '{1'b1, 19'h50105, 16'h0001,  0, 1, 0, 0, 16'h0000, 4'hE, 1'b0, 2'd1, 8'h05, 16'h0001, 2'd1, 8'h10};
        vecs[6] = '{1'b0, 19'h50220, 16'h0000, -1, 0, 1, 1, 16'h0000, 4'hE, 1'b1, 2'd1, 8'h05, 16'h0001, 2'd2, 8'h20};
        vecs[7] = '{1'b0, 19'h50315, 16'h5A5A,  0, 0, 1, 1, 16'h5A5A, 4'hE, 1'b1, 2'd1, 8'h05, 16'h0001, 2'd3, 8'h15};

        // Reset state
        repeat (3) @(negedge CLK);
        RST_N = 1'b1;
        @(negedge CLK);
        chk("rst_ad_oe",   AD_OE,     0);
        chk("rst_ad_out",  AD_OUT,    0);
        chk("rst_wr_valid",WR_VALID,  0);
        chk("rst_toggle",  WR_TOGGLE, 0);
        chk("rst_rd_req",  RD_REQ,    0);
        chk("rst_rd_late", RD_LATE,   0);
        chk("rst_wr_data", WR_DATA,   0);

        // Table-driven transactions
        for (int i = 0; i < 8; i++) begin
            w0 = wr_cnt; r0 = rd_cnt; o0 = oe_cnt;
            if (vecs[i].is_wr) begin
                bus_write(vecs[i].addr, vecs[i].data);
            end else begin
                bus_read(vecs[i].addr, vecs[i].dly, vecs[i].data, out_s, oe_s);
            end
            $display("txn %0d %s addr=%05h data=%04h wr_valid=%0d rd_req=%0d toggle=%h rd_late=%0d",
                     i, vecs[i].is_wr ? "write" : "read", vecs[i].addr, vecs[i].data,
                     wr_cnt - w0, rd_cnt - r0, WR_TOGGLE, RD_LATE);
            chk($sformatf("v%0d_wr_pulses", i), wr_cnt - w0, vecs[i].e_wr);
            chk($sformatf("v%0d_rd_pulses", i), rd_cnt - r0, vecs[i].e_rd);
            chk($sformatf("v%0d_oe_active", i), (oe_cnt != o0), vecs[i].e_oe);
            if (!vecs[i].is_wr) begin
                chk($sformatf("v%0d_ad_out_before_noe", i), out_s, vecs[i].e_adout);
                chk($sformatf("v%0d_ad_oe_noe_low", i), oe_s, vecs[i].e_oe);
            end
            chk($sformatf("v%0d_toggle", i),  WR_TOGGLE, vecs[i].e_tog);
            chk($sformatf("v%0d_rd_late", i), RD_LATE,   vecs[i].e_late);
            chk($sformatf("v%0d_wr_ch", i),   WR_CH,     vecs[i].e_wch);
            chk($sformatf("v%0d_wr_reg", i),  WR_REG,    vecs[i].e_wreg);
            chk($sformatf("v%0d_wr_data", i), WR_DATA,   vecs[i].e_wdata);
            chk($sformatf("v%0d_rd_ch", i),   RD_CH,     vecs[i].e_rch);
            chk($sformatf("v%0d_rd_reg", i),  RD_REG,    vecs[i].e_rreg);
            chk($sformatf("v%0d_ad_oe_end", i),  AD_OE,  0);
            chk($sformatf("v%0d_ad_out_end", i), AD_OUT, 0);
        end

        // NE released mid-read before any acknowledge
        r0 = rd_cnt;
        addr_phase(19'h50110);
        AD_IN = '0; NOE = 1'b0;
        repeat (4) @(negedge CLK);
        chk("abort_oe_on", AD_OE, 1);
        NE = 1'b1;
        repeat (2) @(negedge CLK);
        chk("abort_oe_hold", AD_OE, 1);
        @(negedge CLK);
        chk("abort_oe_off", AD_OE, 0);
        NOE = 1'b1; A_HI = '0;
        repeat (6) @(negedge CLK);
        $display("txn abort-read addr=50110 rd_req=%0d ad_oe=%0d", rd_cnt - r0, AD_OE);
        chk("abort_rd_pulses", rd_cnt - r0, 1);
        chk("abort_rd_ch", RD_CH, 1);

        w0 = wr_cnt;
        bus_write(19'h50342, 16'hC0DE);
        $display("txn write addr=50342 data=c0de wr_valid=%0d toggle=%h", wr_cnt - w0, WR_TOGGLE);
        chk("post_abort_wr_pulses", wr_cnt - w0, 1);
        chk("post_abort_wr_ch",     WR_CH,   3);
        chk("post_abort_wr_reg",    WR_REG,  8'h42);
        chk("post_abort_wr_data",   WR_DATA, 16'hC0DE);
        chk("post_abort_toggle",    WR_TOGGLE, 4'h6);

        // Reset asserted during a write data phase
        w0 = wr_cnt;
        addr_phase(19'h50205);
        AD_IN = 16'h7777; NWE = 1'b0;
        repeat (4) @(negedge CLK);
        RST_N = 1'b0;
        #1;
        chk("midrst_toggle",  WR_TOGGLE, 0);
        chk("midrst_rd_late", RD_LATE,   0);
        chk("midrst_wr_data", WR_DATA,   0);
        chk("midrst_wr_ch",   WR_CH,     0);
        chk("midrst_rd_ch",   RD_CH,     0);
        chk("midrst_ad_oe",   AD_OE,     0);
        chk("midrst_wr_valid",WR_VALID,  0);
        @(negedge CLK);
        RST_N = 1'b1;
        repeat (2) @(negedge CLK);
        NWE = 1'b1;
        repeat (2) @(negedge CLK);
        NE = 1'b1; AD_IN = '0; A_HI = '0;
        repeat (6) @(negedge CLK);
        $display("txn reset-aborted-write addr=50205 wr_valid=%0d", wr_cnt - w0);
        chk("midrst_no_wr_pulse", wr_cnt - w0, 0);

        w0 = wr_cnt;
        bus_write(19'h50100, 16'h0042);
        $display("txn write addr=50100 data=0042 wr_valid=%0d toggle=%h", wr_cnt - w0, WR_TOGGLE);
        chk("recover_wr_pulses", wr_cnt - w0, 1);
        chk("recover_wr_ch",     WR_CH,   1);
        chk("recover_wr_reg",    WR_REG,  0);
        chk("recover_wr_data",   WR_DATA, 16'h0042);
        chk("recover_toggle",    WR_TOGGLE, 4'h2);
        chk("recover_rd_late",   RD_LATE, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
